// File: rtl/iis_tx_serializer.sv
// I2S (Philips) transmit serializer: pops one FIFO word per channel slot into a
// shadow register and shifts it out MSB first, with one-bit ws lead and zero-fill.
module iis_tx_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic                  fifo_valid,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rden,
   output logic                  sck,
   output logic                  ws,
   output logic                  sd,
   output logic                  busy,
   output logic                  underrun,
   output logic [31:0]           send_num,
   output logic                  send_finish
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0] BIT_PEN  = BIT_W'(DATA_WIDTH - 2);

   logic [1:0]            state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  sck_q, sck_d;
   logic                  ws_q, ws_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic                  full_q, full_d;
   logic                  pend_q, pend_d;
   logic                  stop_q, stop_d;
   logic                  rden_q, rden_d;
   logic                  under_q, under_d;
   logic                  finish_q, finish_d;
   logic [31:0]           send_num_q, send_num_d;
   logic                  active, fall;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      sck_d      = sck_q;
      ws_d       = ws_q;
      shift_d    = shift_q;
      shadow_d   = shadow_q;
      full_d     = full_q;
      pend_d     = pend_q;
      stop_d     = stop_q;
      rden_d     = 1'b0;
      under_d    = 1'b0;
      finish_d   = 1'b0;
      send_num_d = send_num_q;

      active = (state_q == S_RUN) || (state_q == S_STOP);
      fall   = active && sck_q && (div_q == DIV_LAST);

      if (active) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            sck_d = ~sck_q;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end else begin
         div_d = '0;
         sck_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            ws_d    = 1'b1;
            shift_d = '0;
            stop_d  = 1'b0;
            if (tx_en) state_d = S_PRIME;
         end
         S_PRIME: begin
            // The lead-in period behaves as the last bit of a virtual right slot.
            if (full_q) begin
               state_d = S_RUN;
               ws_d    = 1'b0;
               shift_d = '0;
               bit_d   = BIT_LAST;
            end else if (!tx_en) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (!tx_en) stop_d = 1'b1;
            if (fall) begin
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
                  // ws already reflects the slot being started here
                  if (ws_q && (stop_q || !tx_en)) state_d = S_STOP;
                  if (full_q) begin
                     shift_d    = shadow_q;
                     full_d     = 1'b0;
                     send_num_d = send_num_q + 32'd1;
                  end else begin
                     shift_d = '0;
                     under_d = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                  if (bit_q == BIT_PEN) ws_d = ~ws_q;
               end
            end
         end
         S_STOP: begin
            if (fall) begin
               if (bit_q == BIT_LAST) begin
                  state_d  = S_IDLE;
                  shift_d  = '0;
                  ws_d     = 1'b1;
                  full_d   = 1'b0;
                  stop_d   = 1'b0;
                  finish_d = 1'b1;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (((state_q == S_PRIME) || (state_q == S_RUN)) && !full_q && !pend_q && !fifo_empty) begin
         rden_d = 1'b1;
         pend_d = 1'b1;
      end

      // A word landing on a slot boundary refills shadow for the following slot.
      if (fifo_valid) begin
         pend_d = 1'b0;
         if (state_q != S_STOP) begin
            shadow_d = fifo_dout;
            full_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         sck_q      <= 1'b0;
         ws_q       <= 1'b1;
         shift_q    <= '0;
         shadow_q   <= '0;
         full_q     <= 1'b0;
         pend_q     <= 1'b0;
         stop_q     <= 1'b0;
         rden_q     <= 1'b0;
         under_q    <= 1'b0;
         finish_q   <= 1'b0;
         send_num_q <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         sck_q      <= sck_d;
         ws_q       <= ws_d;
         shift_q    <= shift_d;
         shadow_q   <= shadow_d;
         full_q     <= full_d;
         pend_q     <= pend_d;
         stop_q     <= stop_d;
         rden_q     <= rden_d;
         under_q    <= under_d;
         finish_q   <= finish_d;
         send_num_q <= send_num_d;
      end
   end

   assign fifo_rden   = rden_q;
   assign sck         = sck_q;
   assign ws          = ws_q;
   assign sd          = shift_q[DATA_WIDTH-1];
   assign busy        = (state_q != S_IDLE);
   assign underrun    = under_q;
   assign send_num    = send_num_q;
   assign send_finish = finish_q;

endmodule

// File: tb/tb_iis_tx_serializer.sv
// Bench for iis_tx_serializer: FIFO model plus a bit-level stream model checked
// on every sck rise, with directed frames and literal pins on the captured words.
module tb_iis_tx_serializer;
   localparam int DW      = 16;
   localparam int CLK_DIV = 2;

   logic          clk_in = 1'b0;
   logic          rst = 1'b1;
   logic          tx_en = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_valid = 1'b0;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_rden, sck, ws, sd, busy, underrun, send_finish;
   logic [31:0]   send_num;

   iis_tx_serializer #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV)) dut (
      .clk_in(clk_in), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
      .fifo_valid(fifo_valid), .fifo_dout(fifo_dout), .fifo_rden(fifo_rden),
      .sck(sck), .ws(ws), .sd(sd), .busy(busy), .underrun(underrun),
      .send_num(send_num), .send_finish(send_finish));

   always #5 clk_in = ~clk_in;

   typedef struct packed { logic ws; logic sd; } bit_t;

   bit_t          exp_q[$];
   bit_t          cap_q[$];
   logic [DW-1:0] fq[$];
   logic [DW-1:0] slots[$];
   int vectors = 0, miscompares = 0;
   int n_under = 0, n_fin = 0, n_rden = 0, n_rise = 0, pops = 0, cyc = 0;
   bit fifo_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // FIFO read port: data and valid one cycle after the pop strobe.
   initial begin
      forever begin
         @(posedge clk_in); #1;
         fifo_valid = 1'b0;
         if (rst) fifo_pend = 1'b0;
         else begin
            if (fifo_pend && fq.size() > 0) begin
               fifo_dout  = fq.pop_front();
               fifo_valid = 1'b1;
               pops++;
            end
            fifo_pend = fifo_rden;
            if (fifo_rden) n_rden++;
         end
         fifo_empty = ((fq.size() - (fifo_pend ? 1 : 0)) <= 0);
      end
   end

   // Receiver side: every sck rise is one bit of the expected stream.
   initial begin
      logic prev_sck;
      int   last_rise;
      bit_t e;
      prev_sck  = 1'b0;
      last_rise = -1;
      forever begin
         @(negedge clk_in);
         cyc++;
         if (rst) begin
            prev_sck  = 1'b0;
            last_rise = -1;
         end else begin
            if (!busy) last_rise = -1;
            if (sck && !prev_sck) begin
               n_rise++;
               if (exp_q.size() == 0) check("sck_extra_rise", 32'(cap_q.size()), 32'hFFFF_FFFF);
               else begin
                  e = exp_q.pop_front();
                  check($sformatf("bit%0d_ws_sd", cap_q.size()), {30'd0, ws, sd}, {30'd0, e.ws, e.sd});
               end
               if (last_rise >= 0) check("sck_period", 32'(cyc - last_rise), 32'(2 * CLK_DIV));
               last_rise = cyc;
               cap_q.push_back({ws, sd});
            end
            prev_sck = sck;
            if (underrun) n_under++;
            if (send_finish) n_fin++;
         end
      end
   end

   // Lead-in bit, then each slot MSB first; ws changes one bit early except after the last slot.
   task automatic build_exp();
      int n;
      bit_t b;
      exp_q.delete();
      cap_q.delete();
      exp_q.push_back(bit_t'(2'b00));
      n = slots.size();
      for (int s = 0; s < n; s++)
         for (int k = 0; k < DW; k++) begin
            b.sd = slots[s][DW-1-k];
            b.ws = (k == DW-1 && s != n-1) ? (((s+1) % 2) == 1) : ((s % 2) == 1);
            exp_q.push_back(b);
         end
   endtask

   function automatic logic [DW-1:0] cap_word(input int start);
      logic [DW-1:0] w;
      w = '0;
      for (int k = 0; k < DW; k++)
         if (start + k < cap_q.size()) w = {w[DW-2:0], cap_q[start+k].sd};
      return w;
   endfunction

   task automatic do_reset();
      @(negedge clk_in);
      rst   = 1'b1;
      tx_en = 1'b0;
      fq.delete();
      exp_q.delete();
      repeat (2) @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic run_frame(input logic [31:0] drop_num);
      int i;
      build_exp();
      n_under = 0; n_fin = 0; n_rden = 0; pops = 0;
      fifo_empty = (fq.size() == 0);
      @(negedge clk_in);
      tx_en = 1'b1;
      i = 0;
      while (send_num !== drop_num && i < 3000) begin @(negedge clk_in); i++; end
      check("reach_drop_point", send_num, drop_num);
      tx_en = 1'b0;
      i = 0;
      while (n_fin == 0 && i < 3000) begin @(negedge clk_in); i++; end
      repeat (10) @(negedge clk_in);
      check("finish_pulses", 32'(n_fin), 32'd1);
      check("bits_remaining", 32'(exp_q.size()), 32'd0);
      check("stop_sck_ws_sd_busy", {28'd0, sck, ws, sd, busy}, 32'b0100);
   endtask

   initial begin
      int i;
      repeat (3) @(negedge clk_in);
      check("rst_sck", {31'd0, sck}, 32'd0);
      check("rst_ws", {31'd0, ws}, 32'd1);
      check("rst_sd", {31'd0, sd}, 32'd0);
      check("rst_rden", {31'd0, fifo_rden}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      check("rst_send_num", send_num, 32'd0);
      check("rst_finish", {31'd0, send_finish}, 32'd0);
      rst = 1'b0;
      @(negedge clk_in);

      // Two-word frame, dropped during the left slot.
      fq    = '{16'hA5C3, 16'h0F0F};
      slots = '{16'hA5C3, 16'h0F0F};
      run_frame(32'd1);
      check("lr_cap_len", 32'(cap_q.size()), 32'd33);
      if (cap_q.size() >= 33) begin
         check("lr_left_word", {16'd0, cap_word(1)}, 32'h0000_A5C3);
         check("lr_right_word", {16'd0, cap_word(17)}, 32'h0000_0F0F);
         check("lr_leadin_ws", {31'd0, cap_q[0].ws}, 32'd0);
         check("lr_left_b14_ws", {31'd0, cap_q[15].ws}, 32'd0);
         check("lr_left_b15_ws", {31'd0, cap_q[16].ws}, 32'd1);
         check("lr_right_b15_ws", {31'd0, cap_q[32].ws}, 32'd1);
      end
      check("lr_send_num", send_num, 32'd2);
      check("lr_underruns", 32'(n_under), 32'd0);
      check("lr_pops", 32'(pops), 32'd2);

      // Single sample: right slot zero-filled.
      do_reset();
      fq    = '{16'h8001};
      slots = '{16'h8001, 16'h0000};
      run_frame(32'd1);
      check("one_left_word", {16'd0, cap_word(1)}, 32'h0000_8001);
      check("one_right_word", {16'd0, cap_word(17)}, 32'h0);
      check("one_underruns", 32'(n_under), 32'd1);
      check("one_send_num", send_num, 32'd1);

      // Eight samples streamed, stop requested in the fourth left slot.
      do_reset();
      fq    = '{16'h1357, 16'h2468, 16'hFFFF, 16'h0000, 16'h8000,
                16'h0001, 16'hC3A5, 16'h5A5A, 16'hDEAD, 16'hBEEF};
      slots = '{16'h1357, 16'h2468, 16'hFFFF, 16'h0000, 16'h8000,
                16'h0001, 16'hC3A5, 16'h5A5A};
      run_frame(32'd7);
      check("str_last_word", {16'd0, cap_word(113)}, 32'h0000_5A5A);
      check("str_send_num", send_num, 32'd8);
      check("str_pops", 32'(pops), 32'd8);
      check("str_left_in_fifo", 32'(fq.size()), 32'd2);
      check("str_underruns", 32'(n_under), 32'd0);

      // Empty FIFO: parked in PRIME, then abort.
      do_reset();
      exp_q.delete();
      n_rden = 0; n_fin = 0; n_rise = 0;
      tx_en = 1'b1;
      repeat (40) @(negedge clk_in);
      check("prime_busy", {31'd0, busy}, 32'd1);
      check("prime_no_rden", 32'(n_rden), 32'd0);
      check("prime_no_sck", 32'(n_rise), 32'd0);
      tx_en = 1'b0;
      repeat (3) @(negedge clk_in);
      check("prime_abort_busy", {31'd0, busy}, 32'd0);
      check("prime_abort_finish", 32'(n_fin), 32'd0);

      // send_num wraps.
      do_reset();
      force dut.send_num_q = 32'hFFFF_FFFF;
      @(negedge clk_in);
      release dut.send_num_q;
      @(negedge clk_in);
      check("wrap_preset", send_num, 32'hFFFF_FFFF);
      fq    = '{16'h3C5A};
      slots = '{16'h3C5A, 16'h0000};
      run_frame(32'd0);
      check("wrap_send_num", send_num, 32'd0);
      check("wrap_underruns", 32'(n_under), 32'd1);

      // Reset while streaming.
      do_reset();
      fq    = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
      slots = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
      build_exp();
      fifo_empty = 1'b0;
      @(negedge clk_in);
      tx_en = 1'b1;
      i = 0;
      while (send_num !== 32'd1 && i < 3000) begin @(negedge clk_in); i++; end
      repeat (6) @(negedge clk_in);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      exp_q.delete();
      fq.delete();
      tx_en = 1'b0;
      @(negedge clk_in);
      check("mid_rst_sck", {31'd0, sck}, 32'd0);
      check("mid_rst_ws", {31'd0, ws}, 32'd1);
      check("mid_rst_sd", {31'd0, sd}, 32'd0);
      check("mid_rst_send_num", send_num, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk_in);
      check("post_rst_idle", {29'd0, busy, sck, ws}, 32'b001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
